utmi_rx_feeder: RTL and testbench

Synthesizable UTMI receive-side driver that sits directly upstream of the USB function core's PHY receive inputs (DataIn/RxValid/RxActive/RxError). It converts a byte stream with a valid/ready handshake and a last-byte marker into UTMI-timed receive packets. It adds programmable SYNC lead, bit-stuff holes, an EOP trail and an inter-packet gap. Underrun detection and per-byte error injection are included, so the core's packet decoder can be exercised in bench and FPGA bring-up.

---
 rtl/utmi_rx_feeder.sv | 169 ++++++++++++++++
 tb/tb_utmi_rx_feeder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/utmi_rx_feeder.sv
// UTMI receive-side driver: turns a valid/ready byte stream into RxActive/RxValid/RxError
// packets with SYNC lead, optional bit-stuff holes, EOP trail, inter-packet gap and underrun abort.
module utmi_rx_feeder #(
  parameter int LEAD_CYC     = 2,
  parameter int TRAIL_CYC    = 2,
  parameter int GAP_CYC      = 4,
  parameter int STUFF_PERIOD = 0,
  parameter int UNDERRUN_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  input  logic        in_err_i,
  output logic        in_ready_o,
  output logic [7:0]  utmi_data_o,
  output logic        utmi_rxvalid_o,
  output logic        utmi_rxactive_o,
  output logic        utmi_rxerror_o,
  output logic        busy_o,
  output logic [15:0] pkt_cnt_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_DATA,
    S_TRAIL,
    S_GAP,
    S_DROP
  } state_t;

  state_t      state, state_nx;
  logic [15:0] phase_cnt, phase_cnt_nx;
  logic [15:0] starve_cnt, starve_cnt_nx;
  logic [15:0] byte_cnt, byte_cnt_nx;
  logic        hole_q, hole_nx;
  logic        drop_q, drop_nx;
  logic        pkt_inc;
  logic        accept, take_byte, starved, abort, err_evt;
  logic [15:0] pkt_cnt_q;
  logic [7:0]  err_cnt_q;

  // Ready is a pure function of state so the upstream source never sees a combinational loop.
  always_comb begin
    in_ready_o = 1'b0;
    case (state)
      S_LEAD:  in_ready_o = (phase_cnt == 16'(LEAD_CYC - 1));
      S_DATA:  in_ready_o = !hole_q;
      S_DROP:  in_ready_o = 1'b1;
      default: in_ready_o = 1'b0;
    endcase
  end

  assign accept    = in_valid_i & in_ready_o;
  assign take_byte = accept & ((state == S_LEAD) | (state == S_DATA));
  assign starved   = (state == S_DATA) & in_ready_o & !in_valid_i;
  assign abort     = starved & (starve_cnt == 16'(UNDERRUN_MAX - 1));
  assign err_evt   = (take_byte & in_err_i) | abort;
  assign busy_o    = (state != S_IDLE);
  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;

  always_comb begin
    state_nx      = state;
    phase_cnt_nx  = phase_cnt;
    starve_cnt_nx = starve_cnt;
    byte_cnt_nx   = byte_cnt;
    hole_nx       = 1'b0;
    drop_nx       = drop_q;
    pkt_inc       = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable_i && in_valid_i) begin
          state_nx      = S_LEAD;
          phase_cnt_nx  = '0;
          starve_cnt_nx = '0;
          byte_cnt_nx   = '0;
        end
      end
      S_LEAD: begin
        if (!take_byte) begin
          if (phase_cnt == 16'(LEAD_CYC - 1)) state_nx = S_DATA;
          else phase_cnt_nx = phase_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (abort) begin
          state_nx     = S_TRAIL;
          phase_cnt_nx = '0;
          drop_nx      = 1'b1;
        end else if (starved) begin
          starve_cnt_nx = starve_cnt + 16'd1;
        end
      end
      S_TRAIL: begin
        if (phase_cnt == 16'(TRAIL_CYC)) begin
          state_nx     = S_GAP;
          phase_cnt_nx = '0;
          pkt_inc      = !drop_q;
        end else begin
          phase_cnt_nx = phase_cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (phase_cnt == 16'(GAP_CYC - 1)) state_nx = drop_q ? S_DROP : S_IDLE;
        else phase_cnt_nx = phase_cnt + 16'd1;
      end
      S_DROP: begin
        if (accept && in_last_i) begin
          state_nx = S_IDLE;
          drop_nx  = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Byte delivery is shared by the last LEAD cycle and DATA; the stuff hole never follows the last byte.
    if (take_byte) begin
      starve_cnt_nx = '0;
      if (in_last_i) begin
        state_nx     = S_TRAIL;
        phase_cnt_nx = '0;
      end else begin
        state_nx = S_DATA;
        if (STUFF_PERIOD > 0 && byte_cnt == 16'(STUFF_PERIOD - 1)) begin
          hole_nx     = 1'b1;
          byte_cnt_nx = '0;
        end else begin
          byte_cnt_nx = byte_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      phase_cnt       <= '0;
      starve_cnt      <= '0;
      byte_cnt        <= '0;
      hole_q          <= 1'b0;
      drop_q          <= 1'b0;
      pkt_cnt_q       <= '0;
      err_cnt_q       <= '0;
      utmi_data_o     <= '0;
      utmi_rxvalid_o  <= 1'b0;
      utmi_rxactive_o <= 1'b0;
      utmi_rxerror_o  <= 1'b0;
    end else begin
      state           <= state_nx;
      phase_cnt       <= phase_cnt_nx;
      starve_cnt      <= starve_cnt_nx;
      byte_cnt        <= byte_cnt_nx;
      hole_q          <= hole_nx;
      drop_q          <= drop_nx;
      utmi_rxvalid_o  <= take_byte;
      utmi_rxerror_o  <= err_evt;
      utmi_rxactive_o <= (state_nx == S_LEAD) | (state_nx == S_DATA) | (state_nx == S_TRAIL);
      if (take_byte) utmi_data_o <= in_data_i;
      if (pkt_inc) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (err_evt && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_utmi_rx_feeder.sv
// Bench for utmi_rx_feeder: per-cycle comparison against packet timing derived arithmetically
// from the lead/stuff/trail/gap rules, with directed and random packets.
module tb_utmi_rx_feeder;
  localparam int LEAD  = 2;
  localparam int TRAIL = 2;
  localparam int GAP   = 4;
  localparam int UMAX  = 8;
  localparam int SP    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic sel = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_err = 1'b0;

  logic        rdy0, val0, act0, rer0, busy0, rdy1, val1, act1, rer1, busy1;
  logic [7:0]  dat0, dat1, ec0, ec1;
  logic [15:0] pc0, pc1;

  logic        rdy, o_val, o_act, o_rer, o_busy;
  logic [7:0]  o_dat, o_ec;
  logic [15:0] o_pc;

  always #5 clk = ~clk;

  utmi_rx_feeder #(.LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL), .GAP_CYC(GAP), .STUFF_PERIOD(0),
                   .UNDERRUN_MAX(UMAX)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en & !sel), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_err_i(in_err), .in_ready_o(rdy0), .utmi_data_o(dat0),
    .utmi_rxvalid_o(val0), .utmi_rxactive_o(act0), .utmi_rxerror_o(rer0), .busy_o(busy0),
    .pkt_cnt_o(pc0), .err_cnt_o(ec0));

  utmi_rx_feeder #(.LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL), .GAP_CYC(GAP), .STUFF_PERIOD(SP),
                   .UNDERRUN_MAX(UMAX)) dut_s (
    .clk_i(clk), .rst_i(rst), .enable_i(en & sel), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_err_i(in_err), .in_ready_o(rdy1), .utmi_data_o(dat1),
    .utmi_rxvalid_o(val1), .utmi_rxactive_o(act1), .utmi_rxerror_o(rer1), .busy_o(busy1),
    .pkt_cnt_o(pc1), .err_cnt_o(ec1));

  assign rdy    = sel ? rdy1  : rdy0;
  assign o_val  = sel ? val1  : val0;
  assign o_act  = sel ? act1  : act0;
  assign o_rer  = sel ? rer1  : rer0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_dat  = sel ? dat1  : dat0;
  assign o_ec   = sel ? ec1   : ec0;
  assign o_pc   = sel ? pc1   : pc0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0, idle_from = 0, holes_seen = 0;
  logic [15:0] pkt_base = '0;
  logic [7:0]  err_base = '0, last_data = '0;
  logic [7:0]  pd [8];
  logic        pe [8];

  function automatic logic [7:0] sat8(input logic [7:0] a, input int b);
    int t;
    t = int'(a) + b;
    return (t > 255) ? 8'hFF : 8'(t);
  endfunction

  // Cycle in which byte k of a packet whose enable/valid cycle is s appears on RxValid.
  function automatic int dlv(input int s, input int k, input int p);
    return s + LEAD + 1 + k + ((p > 0) ? k / p : 0);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_cycle(input logic act, input logic val, input logic [7:0] data,
                           input logic rerr, input logic busy, input logic [15:0] pkt,
                           input logic [7:0] errc);
    chk("rxactive", 16'(o_act), 16'(act));
    chk("rxvalid",  16'(o_val), 16'(val));
    chk("data",     16'(o_dat), 16'(data));
    chk("rxerror",  16'(o_rer), 16'(rerr));
    chk("busy",     16'(o_busy), 16'(busy));
    chk("pkt_cnt",  o_pc, pkt);
    chk("err_cnt",  16'(o_ec), 16'(errc));
  endtask

  // Present byte idx (or nothing) for the current cycle, then record whether it is taken.
  task automatic drive(inout int idx, input int n);
    if (idx < n) begin
      in_valid = 1'b1; in_data = pd[idx]; in_last = (idx == n - 1); in_err = pe[idx];
    end else begin
      in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    end
    if (in_valid && rdy) idx++;
  endtask

  task automatic run_pkt(input int n);
    int s, p, dl, idx, errs;
    logic ev, er;
    p  = sel ? SP : 0;
    s  = (cyc + 1 > idle_from) ? cyc + 1 : idle_from;
    dl = dlv(s, n - 1, p);
    idx = 0; errs = 0; holes_seen = 0;
    for (int c = cyc + 1; c <= dl + TRAIL + 1; c++) begin
      @(negedge clk);
      ev = 1'b0; er = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (dlv(s, k, p) == c) begin
          ev = 1'b1; er = pe[k]; last_data = pd[k];
          if (pe[k]) errs++;
        end
      end
      if (!o_val && c > dlv(s, 0, p) && c < dl) holes_seen++;
      chk_cycle(c >= s + 1 && c <= dl + TRAIL, ev, last_data, er,
                (c < idle_from) || (c >= s + 1),
                pkt_base + 16'(c >= dl + TRAIL + 1), sat8(err_base, errs));
      drive(idx, n);
    end
    pkt_base  = pkt_base + 16'd1;
    err_base  = sat8(err_base, errs);
    idle_from = dl + TRAIL + GAP + 1;
  endtask

  // First byte delivered, then source starves long enough to abort; the rest is drained in DROP.
  task automatic run_underrun();
    int s, idx;
    logic [7:0] e0;
    s = (cyc + 1 > idle_from) ? cyc + 1 : idle_from;
    idx = 0; e0 = err_base;
    for (int c = cyc + 1; c <= s + 21; c++) begin
      @(negedge clk);
      if (c == s + 3) last_data = pd[0];
      chk_cycle(c >= s + 1 && c <= s + 13, c == s + 3, last_data, c == s + 11,
                (c < idle_from) || (c >= s + 1 && c <= s + 20), pkt_base,
                (c >= s + 11) ? sat8(e0, 1) : e0);
      if (idx > 0 && c < s + 12) begin
        in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
      end else begin
        drive(idx, 4);
      end
    end
    err_base  = sat8(e0, 1);
    idle_from = s + 21;
  endtask

  task automatic random_pkt();
    int n;
    n = $urandom_range(1, 6);
    for (int k = 0; k < n; k++) begin
      pd[k] = 8'($urandom);
      pe[k] = ($urandom_range(0, 3) == 0);
    end
    run_pkt(n);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("ready_reset", 16'(rdy), 16'h0000);
    rst = 1'b0;
    pkt_base = '0; err_base = '0; last_data = '0; idle_from = cyc;
  endtask

  initial begin
    int s;
    for (int k = 0; k < 8; k++) begin pd[k] = '0; pe[k] = 1'b0; end
    do_reset();

    pd[0] = 8'hC3; pd[1] = 8'h01; pd[2] = 8'h02;
    run_pkt(3);
    pd[0] = 8'hA5; pd[1] = 8'h5A; pd[2] = 8'hFF;
    run_pkt(3);

    pd[0] = 8'h10; pd[1] = 8'h20; pd[2] = 8'h30; pd[3] = 8'h40;
    pe[1] = 1'b1;
    run_pkt(4);
    pe[1] = 1'b0;

    pd[0] = 8'h61; pd[1] = 8'h62; pd[2] = 8'h63; pd[3] = 8'h64;
    run_underrun();
    pd[0] = 8'h99;
    run_pkt(1);

    repeat (20) random_pkt();

    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    pkt_base = 16'hFFFF;
    chk("pkt_preload", o_pc, 16'hFFFF);
    pd[0] = 8'h77; pe[0] = 1'b0;
    run_pkt(1);

    force dut.err_cnt_q = 8'hFF;
    #1;
    release dut.err_cnt_q;
    err_base = 8'hFF;
    pd[0] = 8'h11; pe[0] = 1'b1;
    run_pkt(1);
    pe[0] = 1'b0;

    s = (cyc + 1 > idle_from) ? cyc + 1 : idle_from;
    in_valid = 1'b1; in_last = 1'b0; in_err = 1'b0; in_data = 8'h5A;
    while (cyc < s + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    pkt_base = '0; err_base = '0; last_data = '0; idle_from = cyc;
    pd[0] = 8'h3C; pd[1] = 8'hC3;
    run_pkt(2);

    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) pd[k] = 8'(8'h10 + k);
    run_pkt(5);
    chk("stuff_holes", 16'(holes_seen), 16'd2);
    repeat (6) random_pkt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
